// File: rtl/prog_sequencer_pkg.sv
// ============================================================================
// core_pkg : shared opcodes, FSM states, field slices and default branch LUT
// Revision : 1.0
// ============================================================================
`default_nettype none

package core_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_LDR = 3'b100,
    OP_STR = 3'b101,
    OP_BR  = 3'b110,
    OP_BRZ = 3'b111
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam logic [6:0] HALT_TGT = 7'h7F;

  // Entry 0 sits in the least significant slot.
  localparam logic [7:0][6:0] LUT_DEFAULT = {
    7'd0, 7'd0, 7'd19, 7'd26, 7'd26, HALT_TGT, 7'd0, 7'd15
  };

  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;
  localparam int RD_MSB = 5;
  localparam int RD_LSB = 3;
  localparam int RS_MSB = 2;
  localparam int RS_LSB = 0;

endpackage

`default_nettype wire

// File: rtl/prog_sequencer_if.sv
// ============================================================================
// prog_sequencer_if : host/ROM/datapath bundle around the sequencer
// Revision          : 1.0
// ============================================================================
`default_nettype none

interface prog_sequencer_if #(
  parameter int PC_W  = 7,
  parameter int CYC_W = 16
);

  logic             Start;
  logic             Ack;
  logic [PC_W-1:0]  InstAddress;
  logic [8:0]       InstIn;
  logic             ZeroIn;
  logic [2:0]       Opcode;
  logic [2:0]       RdSel;
  logic [2:0]       RsImm;
  logic             RegWrEn;
  logic             MemRdEn;
  logic             MemWrEn;
  logic             Busy;
  logic             Done;
  logic             Fault;
  logic [CYC_W-1:0] CycleCount;

  modport master (
    output Start, Ack, InstIn, ZeroIn,
    input  InstAddress, Opcode, RdSel, RsImm, RegWrEn, MemRdEn, MemWrEn,
           Busy, Done, Fault, CycleCount
  );

  modport slave (
    input  Start, Ack, InstIn, ZeroIn,
    output InstAddress, Opcode, RdSel, RsImm, RegWrEn, MemRdEn, MemWrEn,
           Busy, Done, Fault, CycleCount
  );

endinterface

`default_nettype wire

// File: rtl/prog_sequencer_branch_lut.sv
// ============================================================================
// branch_lut : combinational 8x7 branch-target table, replaceable per program
// Revision   : 1.0
// ============================================================================
`default_nettype none

module branch_lut
  import core_pkg::*;
#(
  parameter logic [7:0][6:0] TABLE = LUT_DEFAULT
) (
  input  logic [2:0] rs_imm,
  output logic [6:0] target
);

  assign target = TABLE[rs_imm];

endmodule

`default_nettype wire

// File: rtl/prog_sequencer.sv
// ============================================================================
// prog_sequencer : program counter and control FSM for the 9-bit core
// Revision       : 1.0
// ============================================================================
`default_nettype none

module prog_sequencer #(
  parameter int                PC_W      = 7,
  parameter logic [PC_W-1:0]   START_PC  = '0,
  parameter int                MEM_LAT   = 2,
  parameter logic [6:0]        HALT_TGT  = 7'h7F,
  parameter int                CYC_W     = 16,
  parameter logic [7:0][6:0]   LUT_TABLE = core_pkg::LUT_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset_n,
  prog_sequencer_if.slave   bus
);

  import core_pkg::*;

  localparam logic [2:0]      WAIT_INIT = 3'(MEM_LAT - 1);
  localparam logic [PC_W-1:0] PC_MAX    = '1;

  state_t           state;
  logic [PC_W-1:0]  pc;
  logic [8:0]       ir;
  logic [CYC_W-1:0] cyc;
  logic [2:0]       wait_cnt;
  logic             fault;
  logic             regwr;
  logic             memrd;
  logic             memwr;
  logic             busy;
  logic             done;

  op_t        op;
  logic [6:0] tgt;
  logic       take;
  logic       last_pc;

  assign op      = op_t'(ir[OP_MSB:OP_LSB]);
  assign take    = (op == OP_BR) || ((op == OP_BRZ) && bus.ZeroIn);
  assign last_pc = (pc == PC_MAX);

  branch_lut #(
    .TABLE (LUT_TABLE)
  ) u_lut (
    .rs_imm (ir[RS_MSB:RS_LSB]),
    .target (tgt)
  );

  // Strobes are registered on entry to the state that owns them, so they
  // line up with state/IR exactly as a Moore decode would.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state    <= ST_IDLE;
      pc       <= START_PC;
      ir       <= '0;
      cyc      <= '0;
      wait_cnt <= '0;
      fault    <= 1'b0;
      regwr    <= 1'b0;
      memrd    <= 1'b0;
      memwr    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      regwr <= 1'b0;
      memrd <= 1'b0;
      memwr <= 1'b0;
      if ((state == ST_FETCH || state == ST_EXEC || state == ST_MEM) && (cyc != '1))
        cyc <= cyc + 1'b1;

      case (state)
        ST_IDLE: begin
          if (bus.Start) begin
            state <= ST_FETCH;
            pc    <= START_PC;
            cyc   <= '0;
            fault <= 1'b0;
            busy  <= 1'b1;
          end
        end

        ST_FETCH: begin
          ir    <= bus.InstIn;
          state <= ST_EXEC;
          regwr <= ~bus.InstIn[OP_MSB];
        end

        ST_EXEC: begin
          if (op == OP_LDR || op == OP_STR) begin
            state    <= ST_MEM;
            wait_cnt <= WAIT_INIT;
            memrd    <= (op == OP_LDR);
            memwr    <= (op == OP_STR);
            regwr    <= (op == OP_LDR) && (WAIT_INIT == 3'd0);
          end else if (take && (tgt == HALT_TGT)) begin
            state <= ST_HALT;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (take) begin
            pc    <= PC_W'(tgt);
            state <= ST_FETCH;
          end else if (last_pc) begin
            fault <= 1'b1;
            state <= ST_HALT;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            pc    <= pc + 1'b1;
            state <= ST_FETCH;
          end
        end

        ST_MEM: begin
          if (wait_cnt == 3'd0) begin
            if (last_pc) begin
              fault <= 1'b1;
              state <= ST_HALT;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              pc    <= pc + 1'b1;
              state <= ST_FETCH;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
            memrd    <= (op == OP_LDR);
            memwr    <= (op == OP_STR);
            regwr    <= (op == OP_LDR) && (wait_cnt == 3'd1);
          end
        end

        ST_HALT: begin
          if (bus.Ack) begin
            state <= ST_IDLE;
            done  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.InstAddress = pc;
  assign bus.Opcode      = ir[OP_MSB:OP_LSB];
  assign bus.RdSel       = ir[RD_MSB:RD_LSB];
  assign bus.RsImm       = ir[RS_MSB:RS_LSB];
  assign bus.RegWrEn     = regwr;
  assign bus.MemRdEn     = memrd;
  assign bus.MemWrEn     = memwr;
  assign bus.Busy        = busy;
  assign bus.Done        = done;
  assign bus.Fault       = fault;
  assign bus.CycleCount  = cyc;

endmodule

`default_nettype wire

// File: tb/tb_prog_sequencer.sv
// ============================================================================
// tb_prog_sequencer : directed self-checking bench for prog_sequencer
// Revision          : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_prog_sequencer;
  import core_pkg::*;

  logic Clk = 1'b0;
  logic Reset_n;
  int   vectors = 0;
  int   miscompares = 0;
  logic [8:0] rom [128];

  always #5 Clk = ~Clk;

  prog_sequencer_if #(.PC_W(7), .CYC_W(16)) bus ();
  prog_sequencer_if #(.PC_W(7), .CYC_W(16)) bus2 ();

  assign bus.InstIn  = rom[bus.InstAddress];
  assign bus2.InstIn = 9'b000_001_010;

  prog_sequencer #(.START_PC(7'd0)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  prog_sequencer #(.START_PC(7'd125)) dut_hi (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus2)
  );

  function automatic logic [8:0] ins(logic [2:0] op, logic [2:0] rd, logic [2:0] rs);
    return {op, rd, rs};
  endfunction

  task automatic step(int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic start_pulse();
    bus.Start = 1'b1; step(1); bus.Start = 1'b0;
  endtask

  task automatic do_ack();
    bus.Ack = 1'b1; step(1); bus.Ack = 1'b0;
  endtask

  task automatic wait_done(string name);
    int n = 0;
    while (bus.Done !== 1'b1 && n < 200) begin step(1); n++; end
    vectors++;
    if (bus.Done !== 1'b1) begin miscompares++; $display("FAIL %s_timeout: Done=%b want 1", name, bus.Done); end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; step(2);
    vectors++; if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin miscompares++; $display("FAIL rst_busy_done: got %b%b want 00", bus.Busy, bus.Done); end
    vectors++; if (bus.Fault !== 1'b0) begin miscompares++; $display("FAIL rst_fault: got %b want 0", bus.Fault); end
    vectors++; if (bus.CycleCount !== 16'd0) begin miscompares++; $display("FAIL rst_cyc: got %0d want 0", bus.CycleCount); end
    vectors++; if (bus.InstAddress !== 7'd0) begin miscompares++; $display("FAIL rst_pc: got %0d want 0", bus.InstAddress); end
    vectors++; if ({bus.RegWrEn, bus.MemRdEn, bus.MemWrEn} !== 3'b000) begin miscompares++; $display("FAIL rst_strobes: got %b want 000", {bus.RegWrEn, bus.MemRdEn, bus.MemWrEn}); end
    vectors++; if (bus.Opcode !== 3'd0) begin miscompares++; $display("FAIL rst_ir: got %b want 000", bus.Opcode); end
    vectors++; if (bus2.InstAddress !== 7'd125) begin miscompares++; $display("FAIL rst_pc_hi: got %0d want 125", bus2.InstAddress); end
    Reset_n = 1'b1; step(1);
  endtask

  task automatic test_alu_timing();
    rom[0] = ins(OP_ADD, 3'd1, 3'd2);
    start_pulse();
    vectors++; if (bus.Busy !== 1'b1 || bus.RegWrEn !== 1'b0) begin miscompares++; $display("FAIL alu_c1: busy/regwr %b%b want 10", bus.Busy, bus.RegWrEn); end
    step(1);
    vectors++; if (bus.RegWrEn !== 1'b1) begin miscompares++; $display("FAIL alu_regwr_c2: got %b want 1", bus.RegWrEn); end
    vectors++; if ({bus.Opcode, bus.RdSel, bus.RsImm} !== 9'b000_001_010) begin miscompares++; $display("FAIL alu_fields: got %b want 000001010", {bus.Opcode, bus.RdSel, bus.RsImm}); end
    step(1);
    vectors++; if (bus.RegWrEn !== 1'b0 || bus.InstAddress !== 7'd1) begin miscompares++; $display("FAIL alu_c3: regwr=%b pc=%0d want 0/1", bus.RegWrEn, bus.InstAddress); end
    step(1);
    vectors++; if (bus.Opcode !== 3'b110 || bus.Done !== 1'b0) begin miscompares++; $display("FAIL alu_c4: op=%b done=%b want 110/0", bus.Opcode, bus.Done); end
    step(1);
    vectors++; if (bus.Done !== 1'b1 || bus.Busy !== 1'b0) begin miscompares++; $display("FAIL alu_c5_done: done/busy %b%b want 10", bus.Done, bus.Busy); end
    vectors++; if (bus.CycleCount !== 16'd4) begin miscompares++; $display("FAIL alu_cyc: got %0d want 4", bus.CycleCount); end
    vectors++; if (bus.InstAddress !== 7'd1 || bus.Fault !== 1'b0) begin miscompares++; $display("FAIL alu_halt_pc: pc=%0d fault=%b want 1/0", bus.InstAddress, bus.Fault); end
    do_ack();
    vectors++; if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin miscompares++; $display("FAIL alu_ack: done/busy %b%b want 00", bus.Done, bus.Busy); end
  endtask

  task automatic test_ack_idle();
    bus.Ack = 1'b1; step(3); bus.Ack = 1'b0;
    vectors++; if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin miscompares++; $display("FAIL ack_idle: busy/done %b%b want 00", bus.Busy, bus.Done); end
    vectors++; if (bus.CycleCount !== 16'd4) begin miscompares++; $display("FAIL ack_idle_cyc: got %0d want 4", bus.CycleCount); end
  endtask

  task automatic test_ldr_timing();
    rom[0] = ins(OP_LDR, 3'd3, 3'd0);
    start_pulse();
    vectors++; if (bus.MemRdEn !== 1'b0) begin miscompares++; $display("FAIL ldr_c1: memrd=%b want 0", bus.MemRdEn); end
    step(1);
    vectors++; if (bus.MemRdEn !== 1'b0 || bus.RegWrEn !== 1'b0) begin miscompares++; $display("FAIL ldr_c2: memrd/regwr %b%b want 00", bus.MemRdEn, bus.RegWrEn); end
    step(1);
    vectors++; if ({bus.MemRdEn, bus.RegWrEn, bus.MemWrEn} !== 3'b100) begin miscompares++; $display("FAIL ldr_c3: rd/rw/wr %b want 100", {bus.MemRdEn, bus.RegWrEn, bus.MemWrEn}); end
    step(1);
    vectors++; if ({bus.MemRdEn, bus.RegWrEn, bus.MemWrEn} !== 3'b110) begin miscompares++; $display("FAIL ldr_c4: rd/rw/wr %b want 110", {bus.MemRdEn, bus.RegWrEn, bus.MemWrEn}); end
    step(1);
    vectors++; if (bus.MemRdEn !== 1'b0 || bus.RegWrEn !== 1'b0 || bus.InstAddress !== 7'd1 || bus.Busy !== 1'b1) begin miscompares++; $display("FAIL ldr_c5: rd=%b rw=%b pc=%0d busy=%b want 0/0/1/1", bus.MemRdEn, bus.RegWrEn, bus.InstAddress, bus.Busy); end
    step(2);
    vectors++; if (bus.Done !== 1'b1 || bus.CycleCount !== 16'd6) begin miscompares++; $display("FAIL ldr_halt: done=%b cyc=%0d want 1/6", bus.Done, bus.CycleCount); end
    wait_done("ldr");
    do_ack();
  endtask

  task automatic test_branches();
    rom[0] = ins(OP_BRZ, 3'd0, 3'd5);
    bus.ZeroIn = 1'b1;
    start_pulse(); step(2);
    vectors++; if (bus.InstAddress !== 7'd19) begin miscompares++; $display("FAIL brz_taken: pc=%0d want 19", bus.InstAddress); end
    wait_done("brz_taken"); do_ack();
    bus.ZeroIn = 1'b0;
    start_pulse(); step(2);
    vectors++; if (bus.InstAddress !== 7'd1) begin miscompares++; $display("FAIL brz_not_taken: pc=%0d want 1", bus.InstAddress); end
    wait_done("brz_nt"); do_ack();
    rom[0] = ins(OP_BR, 3'd0, 3'd3);
    start_pulse(); step(2);
    vectors++; if (bus.InstAddress !== 7'd26) begin miscompares++; $display("FAIL br3_pc0: pc=%0d want 26", bus.InstAddress); end
    wait_done("br3"); do_ack();
    rom[0] = ins(OP_BRZ, 3'd0, 3'd5);
    rom[19] = ins(OP_BR, 3'd0, 3'd3);
    bus.ZeroIn = 1'b1;
    start_pulse(); step(4);
    vectors++; if (bus.InstAddress !== 7'd26) begin miscompares++; $display("FAIL br3_pc19: pc=%0d want 26", bus.InstAddress); end
    wait_done("br3_19");
    vectors++; if (bus.CycleCount !== 16'd6) begin miscompares++; $display("FAIL br_chain_cyc: got %0d want 6", bus.CycleCount); end
    do_ack();
    rom[19] = ins(OP_BR, 3'd0, 3'd2);
    bus.ZeroIn = 1'b0;
  endtask

  task automatic test_overrun();
    bus2.Start = 1'b1; step(1); bus2.Start = 1'b0;
    step(4);
    vectors++; if (bus2.InstAddress !== 7'd127 || bus2.Fault !== 1'b0) begin miscompares++; $display("FAIL ovr_c5: pc=%0d fault=%b want 127/0", bus2.InstAddress, bus2.Fault); end
    step(2);
    vectors++; if (bus2.Done !== 1'b1 || bus2.Fault !== 1'b1 || bus2.Busy !== 1'b0) begin miscompares++; $display("FAIL ovr_halt: done/fault/busy %b%b%b want 110", bus2.Done, bus2.Fault, bus2.Busy); end
    vectors++; if (bus2.InstAddress !== 7'd127 || bus2.CycleCount !== 16'd6) begin miscompares++; $display("FAIL ovr_pc_cyc: pc=%0d cyc=%0d want 127/6", bus2.InstAddress, bus2.CycleCount); end
    step(3);
    vectors++; if (bus2.InstAddress !== 7'd127) begin miscompares++; $display("FAIL ovr_nowrap: pc=%0d want 127", bus2.InstAddress); end
    bus2.Ack = 1'b1; step(1); bus2.Ack = 1'b0;
    bus2.Start = 1'b1; step(1); bus2.Start = 1'b0;
    vectors++; if (bus2.Fault !== 1'b0 || bus2.InstAddress !== 7'd125 || bus2.CycleCount !== 16'd0) begin miscompares++; $display("FAIL ovr_restart: fault=%b pc=%0d cyc=%0d want 0/125/0", bus2.Fault, bus2.InstAddress, bus2.CycleCount); end
    step(6);
    vectors++; if (bus2.Fault !== 1'b1) begin miscompares++; $display("FAIL ovr_refault: got %b want 1", bus2.Fault); end
  endtask

  task automatic test_reset_mid();
    rom[0] = ins(OP_STR, 3'd2, 3'd1);
    start_pulse(); step(2);
    vectors++; if (bus.MemWrEn !== 1'b1 || bus.RegWrEn !== 1'b0) begin miscompares++; $display("FAIL str_mem: wr/rw %b%b want 10", bus.MemWrEn, bus.RegWrEn); end
    Reset_n = 1'b0; step(1);
    vectors++; if ({bus.RegWrEn, bus.MemRdEn, bus.MemWrEn, bus.Busy, bus.Done} !== 5'b0) begin miscompares++; $display("FAIL rstmid_out: got %b want 00000", {bus.RegWrEn, bus.MemRdEn, bus.MemWrEn, bus.Busy, bus.Done}); end
    vectors++; if (bus.CycleCount !== 16'd0 || bus.InstAddress !== 7'd0) begin miscompares++; $display("FAIL rstmid_cyc_pc: cyc=%0d pc=%0d want 0/0", bus.CycleCount, bus.InstAddress); end
    vectors++; if (bus2.Fault !== 1'b0 || bus.Fault !== 1'b0) begin miscompares++; $display("FAIL rstmid_fault: got %b%b want 00", bus.Fault, bus2.Fault); end
    Reset_n = 1'b1; step(3);
    vectors++; if ({bus.RegWrEn, bus.MemRdEn, bus.MemWrEn, bus.Busy} !== 4'b0) begin miscompares++; $display("FAIL rstmid_after: got %b want 0000", {bus.RegWrEn, bus.MemRdEn, bus.MemWrEn, bus.Busy}); end
    rom[0] = ins(OP_ADD, 3'd1, 3'd2);
  endtask

  task automatic test_start_during_exec();
    start_pulse(); step(1);
    bus.Start = 1'b1; step(1);
    vectors++; if (bus.InstAddress !== 7'd1) begin miscompares++; $display("FAIL start_exec: pc=%0d want 1", bus.InstAddress); end
    step(2);
    vectors++; if (bus.Done !== 1'b1) begin miscompares++; $display("FAIL start_exec_done: got %b want 1", bus.Done); end
    step(1);
    vectors++; if (bus.Done !== 1'b1 || bus.Busy !== 1'b0) begin miscompares++; $display("FAIL start_halt_ignored: done/busy %b%b want 10", bus.Done, bus.Busy); end
    bus.Start = 1'b0;
    vectors++; if (bus.CycleCount !== 16'd4) begin miscompares++; $display("FAIL start_exec_cyc: got %0d want 4", bus.CycleCount); end
    do_ack();
  endtask

  task automatic test_start_ack_idle();
    bus.Start = 1'b1; bus.Ack = 1'b1; step(1);
    bus.Start = 1'b0; bus.Ack = 1'b0;
    vectors++; if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) begin miscompares++; $display("FAIL start_ack: busy/done %b%b want 10", bus.Busy, bus.Done); end
    wait_done("start_ack");
    do_ack();
    vectors++; if (bus.Done !== 1'b0) begin miscompares++; $display("FAIL start_ack_final: done=%b want 0", bus.Done); end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = ins(OP_BR, 3'd0, 3'd2);
    bus.Start = 1'b0;  bus.Ack = 1'b0;  bus.ZeroIn = 1'b0;
    bus2.Start = 1'b0; bus2.Ack = 1'b0; bus2.ZeroIn = 1'b0;
    Reset_n = 1'b0;
    test_reset();
    test_alu_timing();
    test_ack_idle();
    test_ldr_timing();
    test_branches();
    test_overrun();
    test_reset_mid();
    test_start_during_exec();
    test_start_ack_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Program-counter and control FSM for the 9-bit-instruction core.
- Drives InstAddress into the 128x9 instruction ROM and latches the returned word.
- Decodes opcode [8:6] and issues one-hot-in-time strobes to the register file, ALU and data memory.
- Resolves BR/BRZ through an 8-entry branch-target lookup table, and runs a Start/Done/Ack handshake with the testbench or top level.

Parameters:
- PC_W, 7, program counter / InstAddress width.
- START_PC, 0, PC loaded on Start.
- MEM_LAT, 2, data-memory access cycles for LDR/STR (1..7).
- HALT_TGT, 7'h7F, LUT value meaning "halt" instead of a jump.
- CYC_W, 16, cycle-counter width.

Ports:
- Clk in 1: clock, all state updates on rising edge.
- Reset_n in 1: synchronous, active-low reset.
- Start in 1: begin program, accepted only in IDLE.
- Ack in 1: host acknowledge of Done, accepted only in HALT.
- InstAddress out PC_W: ROM address (= PC).
- InstIn in 9: ROM data, combinational from InstAddress.
- ZeroIn in 1: datapath zero flag, valid in EXEC.
- Opcode out 3: IR[8:6].
- RdSel out 3: IR[5:3].
- RsImm out 3: IR[2:0].
- RegWrEn out 1: register-file write strobe.
- MemRdEn out 1: data-memory read enable.
- MemWrEn out 1: data-memory write enable.
- Busy out 1: high in FETCH, EXEC and MEM.
- Done out 1: high in HALT.
- Fault out 1: sticky; PC overran 127.
- CycleCount out CYC_W: cycles since Start, saturating.

Behaviour:
- Reset (Reset_n=0 at edge):
  - Regardless of state, go to IDLE.
  - PC=START_PC, IR=0, CycleCount=0, Fault=0, all strobes/Busy/Done=0.
  - Reset mid-program aborts with no further strobes.
- States: IDLE, FETCH, EXEC, MEM, HALT.
- IDLE:
  - Start=1 -> FETCH, PC=START_PC, CycleCount=0, Fault=0.
  - Start=0 -> stay.
  - Ack ignored.
- FETCH: one cycle. InstAddress=PC; IR<=InstIn at the edge; -> EXEC.
- EXEC: one cycle. Opcode/RdSel/RsImm always reflect IR.
  - ADD/SUB/AND/XOR (000-011): RegWrEn=1; PC<=PC+1; -> FETCH.
  - LDR/STR (100/101): -> MEM, wait counter=MEM_LAT-1. PC unchanged.
  - BR (110): tgt=LUT[RsImm].
  - BRZ (111): taken only if ZeroIn=1; not taken -> PC+1.
  - Taken branch, tgt==HALT_TGT -> HALT, PC unchanged.
  - Taken branch, otherwise: PC<=tgt, -> FETCH.
- MEM: MEM_LAT cycles.
  - LDR holds MemRdEn=1 throughout; RegWrEn=1 only on the final cycle.
  - STR holds MemWrEn=1 throughout.
  - When wait counter==0: PC<=PC+1, -> FETCH.
- Sequential PC+1 from 127 (any path): Fault<=1, -> HALT, PC holds 127 (no wrap).
- HALT:
  - Done=1, Busy=0.
  - Ack=1 -> IDLE, Done drops next cycle.
  - Start ignored until IDLE.
- Start asserted while Busy: ignored.
- Start and Ack both high in IDLE: Start wins.
- CycleCount:
  - Increments every cycle in FETCH, EXEC and MEM.
  - Saturates at all-ones; frozen in HALT/IDLE until next Start.
- Strobes are Moore outputs (from state + IR only). At most one of RegWrEn/MemWrEn is high in any cycle.
- Latency:
  - ALU op = 2 cycles.
  - LDR/STR = 2+MEM_LAT cycles.
  - Branch = 2 cycles.
- LUT default contents:
  - 0: 15
  - 1: 0
  - 2: HALT_TGT
  - 3: 26
  - 4: 26
  - 5: 19
  - 6: 0
  - 7: 0

Decomposition:
- Package core_pkg holds:
  - opcode enum (OP_ADD=3'b000 .. OP_BRZ=3'b111);
  - FSM state enum;
  - HALT_TGT and the default LUT contents as localparam array;
  - instruction field slice constants.
- Sub-module branch_lut: combinational 8x7 table, RsImm in, target out. It is swappable per program.

Test Plan:
- ALU op timing: ROM[0]=ADD, ROM[1]=BR 2. Start pulse -> RegWrEn high exactly in cycle 2, then PC=1 fetched, Done in cycle 5, CycleCount=4. Ack -> IDLE, Done=0 next cycle.
- LDR timing: ROM[0]=LDR with MEM_LAT=2 -> MemRdEn high 2 cycles (cycles 3-4), RegWrEn only in cycle 4, PC=1 at cycle 5.
- BRZ both ways: BRZ 5 with ZeroIn=1 -> PC=19; with ZeroIn=0 -> PC=1. BR 3 from any PC -> PC=26.
- PC overrun: all-ADD ROM from START_PC=125 -> Fault=1, Done=1, PC=127, no wrap to 0.
- Reset mid-program: Reset_n low during MEM with MemWrEn=1 -> next cycle IDLE, all strobes 0, Fault=0, CycleCount=0.
- Handshake edge cases:
  - Start during EXEC ignored.
  - Start+Ack together in IDLE -> program starts.
  - Ack in IDLE has no effect.
